// File: rtl/led_pulse_out.sv
// ---------------------------------------------------------------------------
// led_pulse_out
//
// Purpose:
//   Output-side companion to the panel button input block. It stretches
//   single-cycle event pulses into human-visible, active-low LED on-times.
//   A free-running divider produces a slow tick, and each channel stays lit
//   for HOLD ticks after its most recent event.
//
// Parameters:
//   CYCLE : tick period in clk cycles (1250000 gives 40 Hz at 50 MHz)
//   HOLD  : LED on-time in ticks, legal range 1..255
//   NCH   : number of LED channels
//
// Ports:
//   clk    in   1    clock
//   n_rst  in   1    synchronous reset, active-low
//   ev     in   NCH  per-channel event pulse, active-high
//   clr    in   1    synchronous clear of all channels, active-high
//   led_n  out  NCH  registered LED drive, active-low (0 = lit)
//   busy   out  NCH  registered, 1 while the channel is holding
//
// Configuration macro:
//   LED_BLINK_EN : when defined, a holding LED toggles on every counted tick
//                  instead of staying steadily lit.
//
// Handshake: there is none. ev and clr are sampled on every rising clk
//   edge with no back-pressure; an ev held high for several cycles acts as
//   a continuous retrigger.
//
// Observability: per-channel FSM state and remaining tick count live in the
//   packed struct array ch[], which checkers can reach hierarchically.
// ---------------------------------------------------------------------------
module led_pulse_out #(
    parameter int CYCLE = 1250000,
    parameter int HOLD  = 8,
    parameter int NCH   = 3
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [NCH-1:0] ev,
    input  logic           clr,
    output logic [NCH-1:0] led_n,
    output logic [NCH-1:0] busy
);

    localparam int CW = $clog2(CYCLE + 1);
    localparam int RW = $clog2(HOLD + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [RW-1:0] REM_LOAD = RW'(HOLD);
    localparam logic [RW-1:0] REM_ONE  = RW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ch_state_t;

    typedef struct packed {
        ch_state_t       st;
        logic [RW-1:0]   rem;
    } ch_t;

    logic [CW-1:0] cnt;
    logic          tick;
    ch_t           ch [NCH];

    // ------------------------------------------------------------------
    // Tick divider. It is free-running: neither ev nor clr restarts it,
    // so the phase of an event relative to the tick sets the exact
    // on-time, which ranges from (HOLD-1)*CYCLE+1 to HOLD*CYCLE cycles.
    // ------------------------------------------------------------------
    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel IDLE/HOLD machines. clr has the highest priority, then
    // ev. An ev in the same cycle as a tick reloads rem and does not
    // count that tick, so HOLD full ticks always follow the last event.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NCH; i++) begin
                ch[i].st  <= ST_IDLE;
                ch[i].rem <= '0;
            end
            led_n <= '1;
            busy  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr) begin
                    ch[i].st  <= ST_IDLE;
                    ch[i].rem <= '0;
                    led_n[i]  <= 1'b1;
                    busy[i]   <= 1'b0;
                end else if (ev[i]) begin
                    ch[i].st  <= ST_HOLD;
                    ch[i].rem <= REM_LOAD;
                    led_n[i]  <= 1'b0;
                    busy[i]   <= 1'b1;
                end else if (ch[i].st == ST_HOLD && tick) begin
                    // rem is never 0 while holding, so "not 1" means "> 1".
                    if (ch[i].rem == REM_ONE) begin
                        ch[i].st  <= ST_IDLE;
                        ch[i].rem <= '0;
                        led_n[i]  <= 1'b1;
                        busy[i]   <= 1'b0;
                    end else begin
                        ch[i].rem <= ch[i].rem - REM_ONE;
`ifdef LED_BLINK_EN
                        led_n[i]  <= ~led_n[i];
`else
                        led_n[i]  <= 1'b0;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: doc/led_pulse_out.md
Name: led_pulse_out

Overview:
- Output-side companion to the panel button input block: takes single-cycle event pulses and drives active-low board LEDs.
- Each event pulse lights its LED for a visible, human-scale interval measured in slow ticks.
- The tick is generated internally by a free-running divider.
- Sits between the control logic and the LED pins; channel count matches the button inputs (3).

Parameters:
- CYCLE, 1250000, tick period in clk cycles (40 Hz tick at 50 MHz).
- HOLD, 8, LED on-time in ticks (200 ms at 40 Hz); legal range 1..255.
- NCH, 3, number of LED channels.

Ports:
- clk  input  1  clock.
- n_rst  input  1  reset, synchronous, active-low.
- ev  input  NCH  per-channel event pulse, active-high; one cycle per event.
- clr  input  1  synchronous clear of all channels, active-high.
- led_n  output  NCH  LED drive, active-low (0 = lit).
- busy  output  NCH  1 while the channel is in HOLD.

Behaviour:
- Reset (n_rst=0 at a clk edge): cnt=0, every channel IDLE, rem=0, led_n all 1s, busy all 0s.
- Tick divider:
  - cnt counts 0..CYCLE-1 and wraps to 0; width $clog2(CYCLE+1).
  - tick = (cnt==CYCLE-1), a combinational one-cycle strobe.
  - The divider is free-running: not restarted by ev or clr.
- Per-channel FSM, states IDLE and HOLD, with remaining-tick counter rem of width $clog2(HOLD+1). Priority per channel, highest first:
  - 1. clr=1: state<=IDLE, rem<=0, led_n<=1, busy<=0, for all channels.
  - 2. ev[i]=1, any state: state<=HOLD, rem<=HOLD, led_n[i]<=0, busy[i]<=1. This is a retrigger; a tick in the same cycle is ignored for channel i.
  - 3. HOLD, tick=1, rem==1: state<=IDLE, rem<=0, led_n[i]<=1, busy[i]<=0.
  - 4. HOLD, tick=1, rem>1: rem<=rem-1.
  - 5. Otherwise: hold all values.
- Latency and on-time:
  - led_n[i] falls on the first edge after ev[i] is sampled (1 cycle latency).
  - led_n[i] rises on the edge that samples the HOLD-th tick after the event.
  - On-time is between (HOLD-1)*CYCLE+1 and HOLD*CYCLE clk cycles, depending on tick phase.
- Outputs are registered directly (no combinational path from inputs to outputs).
- Channels are fully independent; simultaneous events on several channels are each handled as above.
- Multi-cycle ev high is treated as continuous retrigger: the LED stays lit, and the countdown starts after ev falls.
- Reset asserted mid-HOLD: all outputs return to reset values on that edge; no pending state survives.

Optional Feature:
- Macro LED_BLINK_EN.
- Defined:
  - In HOLD, led_n[i] toggles on every counted tick (rule 4), so the LED blinks.
  - The event still forces led_n[i]=0.
  - Expiry (rule 3) and clr force led_n[i]=1.
  - busy is unchanged.
- Undefined: led_n[i] stays steady 0 for the whole HOLD.

Test Plan (CYCLE=4, HOLD=3, NCH=3, LED_BLINK_EN undefined unless stated):
- Reset, then ev=3'b001 for 1 cycle in a cycle with cnt=0 -> led_n=3'b110 and busy=3'b001 from the next cycle. Ticks fall at +3, +7 and +11 cycles; led_n returns to 3'b111 and busy to 0 at +12.
- As above, second ev[0] pulse at +9 -> rem reloads to 3; LED stays lit until one cycle after the 3rd subsequent tick (+20). Confirm no glitch high at +12.
- ev[1] pulse in a cycle with tick=1 -> that tick is not counted; led_n[1] stays low until 3 further ticks elapse.
- clr=1 while channels 0 and 2 are in HOLD -> led_n=3'b111, busy=0 next cycle. clr and ev[0] in the same cycle -> channel 0 stays IDLE.
- n_rst=0 mid-HOLD for 1 cycle -> all outputs at reset values next cycle; cnt restarts from 0.
- LED_BLINK_EN defined, single ev[2] -> led_n[2] is 0 after the event, 1 after tick 1, 0 after tick 2, then 1 (off) at expiry after tick 3.
